// File: rtl/cache_repl_pkg.sv
// Shared types and helpers for the cache replacement victim selector.
package cache_repl_pkg;

    // Victim-selector control states.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PICK = 2'd2,
        ST_HOLD = 2'd3
    } repl_state_e;

    // Widest valid-bit vector the priority helper handles (NUMWAYS <= 16).
    localparam int unsigned PRIENC_MAXW = 16;

    // Index of the lowest-numbered zero bit; callers pad unused upper bits with ones.
    function automatic logic [3:0] lowest_zero_idx(input logic [PRIENC_MAXW-1:0] bits);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = PRIENC_MAXW - 1; i >= 0; i--) begin
            if (!bits[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lfsr_victim_prienc.sv
// Priority encoder: lowest-index invalid way plus an "any way invalid" flag.
module lfsr_victim_prienc
    import cache_repl_pkg::*;
#(
    parameter  int NUMWAYS = 4,
    localparam int IDXW    = $clog2(NUMWAYS)
) (
    input  logic [NUMWAYS-1:0] i_valid_ways,
    output logic [IDXW-1:0]    o_inv_idx,
    output logic               o_any_inv
);

    logic [PRIENC_MAXW-1:0] w_padded;
    logic [3:0]             w_idx_full;

    // Pad absent ways as valid so they can never be picked, then encode.
    always_comb begin
        w_padded                = {PRIENC_MAXW{1'b1}};
        w_padded[NUMWAYS-1:0]   = i_valid_ways;
        w_idx_full              = lowest_zero_idx(w_padded);
    end

    assign o_inv_idx = IDXW'(w_idx_full);
    assign o_any_inv = ~(&i_valid_ways);

endmodule

// File: rtl/lfsr_victim_select.sv
// Random-replacement victim selector: prefers an invalid way, otherwise draws
// a way from the external LFSR, rejecting out-of-range draws a bounded number
// of times before falling back to the highest way.
module lfsr_victim_select
    import cache_repl_pkg::*;
#(
    parameter  int               NUMWAYS  = 4,
    parameter  int               LFSRW    = 4,
    parameter  logic [LFSRW-1:0] SEED     = {{(LFSRW-1){1'b0}}, 1'b1},
    parameter  int               MAXRETRY = 4,
    localparam int               IDXW     = $clog2(NUMWAYS)
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUMWAYS-1:0] valid_ways,
    input  logic [LFSRW-1:0]   lfsr_val,
    output logic [LFSRW-1:0]   lfsr_seed,
    output logic               lfsr_load,
    output logic               lfsr_enable,
    output logic               victim_valid,
    input  logic               victim_ready,
    output logic [IDXW-1:0]    victim_idx,
    output logic [NUMWAYS-1:0] victim_onehot,
    output logic               victim_was_invalid
);

    localparam int                 RETRYW       = (MAXRETRY < 1) ? 1 : $clog2(MAXRETRY + 1);
    localparam logic [RETRYW-1:0]  MAXRETRY_L   = RETRYW'(MAXRETRY);
    localparam logic [IDXW:0]      NUMWAYS_L    = (IDXW + 1)'(NUMWAYS);
    localparam logic [IDXW-1:0]    FALLBACK_IDX = IDXW'(NUMWAYS - 1);
    localparam logic [NUMWAYS-1:0] ONEHOT_LSB   = {{(NUMWAYS-1){1'b0}}, 1'b1};

    repl_state_e        r_state;
    logic [NUMWAYS-1:0] r_valid_ways;
    logic [RETRYW-1:0]  r_retry;
    logic               r_req_ready;
    logic               r_victim_valid;
    logic [IDXW-1:0]    r_victim_idx;
    logic [NUMWAYS-1:0] r_victim_onehot;
    logic               r_victim_was_invalid;
    logic               r_lfsr_load;
    logic               r_lfsr_enable;

    repl_state_e        w_state_nxt;
    logic [RETRYW-1:0]  w_retry_nxt;
    logic               w_decide;
    logic [IDXW-1:0]    w_idx_nxt;
    logic               w_inv_nxt;
    logic               w_enable_nxt;
    logic               w_accept_req;
    logic [IDXW-1:0]    w_inv_idx;
    logic               w_any_inv;
    logic [IDXW-1:0]    w_cand;

    lfsr_victim_prienc #(
        .NUMWAYS (NUMWAYS)
    ) u_prienc (
        .i_valid_ways (r_valid_ways),
        .o_inv_idx    (w_inv_idx),
        .o_any_inv    (w_any_inv)
    );

    // Candidate way is the low IDXW bits of the LFSR state.
    assign w_cand       = IDXW'(lfsr_val);
    assign w_accept_req = req_valid && r_req_ready;

    // Next-state, retry and victim decision logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_retry_nxt  = r_retry;
        w_decide     = 1'b0;
        w_idx_nxt    = r_victim_idx;
        w_inv_nxt    = r_victim_was_invalid;
        w_enable_nxt = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_accept_req) begin
                    w_state_nxt  = ST_PICK;
                    w_retry_nxt  = {RETRYW{1'b0}};
                    // Every PICK cycle steps the LFSR unless an invalid way short-circuits it.
                    w_enable_nxt = &valid_ways;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PICK: begin
                if (w_any_inv) begin
                    w_state_nxt = ST_HOLD;
                    w_decide    = 1'b1;
                    w_idx_nxt   = w_inv_idx;
                    w_inv_nxt   = 1'b1;
                end else if (r_retry == MAXRETRY_L) begin
                    w_state_nxt = ST_HOLD;
                    w_decide    = 1'b1;
                    w_idx_nxt   = FALLBACK_IDX;
                    w_inv_nxt   = 1'b0;
                end else if ({1'b0, w_cand} < NUMWAYS_L) begin
                    w_state_nxt = ST_HOLD;
                    w_decide    = 1'b1;
                    w_idx_nxt   = w_cand;
                    w_inv_nxt   = 1'b0;
                end else begin
                    w_state_nxt  = ST_PICK;
                    w_retry_nxt  = r_retry + RETRYW'(1'b1);
                    w_enable_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_victim_valid && victim_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset reseeds the LFSR.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            r_state              <= ST_INIT;
            r_valid_ways         <= {NUMWAYS{1'b0}};
            r_retry              <= {RETRYW{1'b0}};
            r_req_ready          <= 1'b0;
            r_victim_valid       <= 1'b0;
            r_victim_idx         <= {IDXW{1'b0}};
            r_victim_onehot      <= {NUMWAYS{1'b0}};
            r_victim_was_invalid <= 1'b0;
            r_lfsr_load          <= 1'b1;
            r_lfsr_enable        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_retry        <= w_retry_nxt;
            r_req_ready    <= (w_state_nxt == ST_IDLE);
            r_victim_valid <= (w_state_nxt == ST_HOLD);
            r_lfsr_load    <= (w_state_nxt == ST_INIT);
            r_lfsr_enable  <= w_enable_nxt;
            if (r_state == ST_IDLE && w_accept_req) begin
                r_valid_ways <= valid_ways;
            end
            if (w_decide) begin
                r_victim_idx         <= w_idx_nxt;
                r_victim_onehot      <= ONEHOT_LSB << w_idx_nxt;
                r_victim_was_invalid <= w_inv_nxt;
            end
        end
    end

    assign req_ready          = r_req_ready;
    assign victim_valid       = r_victim_valid;
    assign victim_idx         = r_victim_idx;
    assign victim_onehot      = r_victim_onehot;
    assign victim_was_invalid = r_victim_was_invalid;
    assign lfsr_load          = r_lfsr_load;
    assign lfsr_enable        = r_lfsr_enable;
    assign lfsr_seed          = SEED;

endmodule

// File: tb/tb_lfsr_victim_select.sv
// Directed bench for lfsr_victim_select: a 4-way instance (A) and a 3-way
// instance (B) share clock and reset; the LFSR state is driven directly.
module tb_lfsr_victim_select;

    logic       clock;
    logic       reset_b;

    logic       a_req_valid, a_req_ready, a_load, a_en, a_vv, a_vr, a_wi;
    logic [3:0] a_valid_ways, a_lfsr, a_seed, a_onehot;
    logic [1:0] a_idx;

    logic       b_req_valid, b_req_ready, b_load, b_en, b_vv, b_vr, b_wi;
    logic [2:0] b_valid_ways, b_onehot;
    logic [3:0] b_lfsr, b_seed;
    logic [1:0] b_idx;

    int checks;
    int failures;
    int a_encnt;
    int b_encnt;
    int overlap;

    lfsr_victim_select #(.NUMWAYS(4), .LFSRW(4), .SEED(4'd1), .MAXRETRY(4)) u_a (
        .clock(clock), .reset_b(reset_b),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .valid_ways(a_valid_ways),
        .lfsr_val(a_lfsr), .lfsr_seed(a_seed), .lfsr_load(a_load), .lfsr_enable(a_en),
        .victim_valid(a_vv), .victim_ready(a_vr), .victim_idx(a_idx),
        .victim_onehot(a_onehot), .victim_was_invalid(a_wi)
    );

    lfsr_victim_select #(.NUMWAYS(3), .LFSRW(4), .SEED(4'd9), .MAXRETRY(4)) u_b (
        .clock(clock), .reset_b(reset_b),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .valid_ways(b_valid_ways),
        .lfsr_val(b_lfsr), .lfsr_seed(b_seed), .lfsr_load(b_load), .lfsr_enable(b_en),
        .victim_valid(b_vv), .victim_ready(b_vr), .victim_idx(b_idx),
        .victim_onehot(b_onehot), .victim_was_invalid(b_wi)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: step past the rising edge, sample at the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        if (a_en) a_encnt++;
        if (b_en) b_encnt++;
        if ((a_en && a_load) || (b_en && b_load)) overlap++;
    endtask

    initial begin
        checks = 0; failures = 0; a_encnt = 0; b_encnt = 0; overlap = 0;
        reset_b = 1'b0;
        a_req_valid = 1'b0; a_valid_ways = 4'b1111; a_lfsr = 4'd0; a_vr = 1'b0;
        b_req_valid = 1'b0; b_valid_ways = 3'b111;  b_lfsr = 4'd0; b_vr = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_load",   a_load, 1);
        check("rst_ready",  a_req_ready, 0);
        check("rst_vv",     a_vv, 0);
        check("rst_idx",    a_idx, 0);
        check("rst_onehot", a_onehot, 0);
        check("rst_wi",     a_wi, 0);
        check("rst_en",     a_en, 0);
        check("seed_a",     a_seed, 4'd1);
        check("seed_b",     b_seed, 4'd9);
        reset_b = 1'b1;
        check("init_load",  a_load, 1);
        tick();
        check("idle_load",  a_load, 0);
        check("idle_ready", a_req_ready, 1);
        check("idle_vv",    a_vv, 0);
        check("idle_ready_b", b_req_ready, 1);

        // Invalid way preferred; valid_ways changes after the handshake are ignored.
        a_encnt = 0;
        a_valid_ways = 4'b1011; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0; a_valid_ways = 4'b0000;
        check("inv_pick_ready", a_req_ready, 0);
        check("inv_pick_vv",    a_vv, 0);
        tick();
        check("inv_vv",     a_vv, 1);
        check("inv_idx",    a_idx, 2);
        check("inv_onehot", a_onehot, 4'b0100);
        check("inv_wi",     a_wi, 1);
        check("inv_encnt",  a_encnt, 0);
        a_vr = 1'b1;
        tick();
        a_vr = 1'b0;
        check("inv_done_vv",    a_vv, 0);
        check("inv_done_ready", a_req_ready, 1);

        // Random pick, all ways valid, LFSR low bits = 2.
        a_encnt = 0;
        a_valid_ways = 4'b1111; a_lfsr = 4'b0110; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick();
        check("rnd_vv",     a_vv, 1);
        check("rnd_idx",    a_idx, 2);
        check("rnd_onehot", a_onehot, 4'b0100);
        check("rnd_wi",     a_wi, 0);
        check("rnd_encnt",  a_encnt, 1);
        a_vr = 1'b1;
        tick();
        a_vr = 1'b0;

        // Rejection on the 3-way instance: draws 3, 3, then 1.
        b_encnt = 0;
        b_valid_ways = 3'b111; b_lfsr = 4'b0011; b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0;
        tick();
        check("rej_c2_vv", b_vv, 0);
        tick();
        check("rej_c3_vv", b_vv, 0);
        b_lfsr = 4'b0001;
        tick();
        check("rej_vv",     b_vv, 1);
        check("rej_idx",    b_idx, 1);
        check("rej_onehot", b_onehot, 3'b010);
        check("rej_wi",     b_wi, 0);
        check("rej_encnt",  b_encnt, 3);
        b_vr = 1'b1;
        tick();
        b_vr = 1'b0;

        // Fallback: draws stuck at 3 until the retry limit.
        b_encnt = 0;
        b_lfsr = 4'b0011; b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("fb_pending_vv", b_vv, 0);
        tick();
        check("fb_vv",     b_vv, 1);
        check("fb_idx",    b_idx, 2);
        check("fb_onehot", b_onehot, 3'b100);
        check("fb_encnt",  b_encnt, 5);
        b_vr = 1'b1;
        tick();
        b_vr = 1'b0;
        check("fb_done_ready", b_req_ready, 1);

        // Backpressure holds the result, then reset during HOLD discards it.
        a_valid_ways = 4'b0111; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_vv",     a_vv, 1);
            check("bp_idx",    a_idx, 3);
            check("bp_onehot", a_onehot, 4'b1000);
            check("bp_wi",     a_wi, 1);
            tick();
        end
        reset_b = 1'b0;
        tick();
        check("mid_rst_vv",    a_vv, 0);
        check("mid_rst_load",  a_load, 1);
        check("mid_rst_ready", a_req_ready, 0);
        check("mid_rst_idx",   a_idx, 0);
        reset_b = 1'b1;
        tick();
        check("reseed_load",  a_load, 0);
        check("reseed_ready", a_req_ready, 1);
        check("no_load_en_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
